wave_osc_gen: RTL and testbench
===============================

Name: wave_osc_gen

Overview:
Parametrised multi-mode periodic waveform generator. It is the successor to the fixed 8-step triangle generator.
- Waveform shape: triangle, sawtooth-up, square or sawtooth-down, selected at run time.
- Step count and output width are set by parameters.
- Period and mode are glitch-free: they are latched only on waveform-cycle boundaries.
- Sits between the note/period control logic and the mixer/DAC path of the synth.

Parameters:
- PERIOD_W, 32, width of period input (clock cycles per waveform cycle).
- STEP_BITS, 3, log2 of steps per waveform cycle (N = 2**STEP_BITS). Legal range is 2 to OUT_W.
- OUT_W, 8, output sample width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  run enable; level-sensitive.
- mode  input  2  waveform select: 0 triangle, 1 saw-up, 2 square, 3 saw-down.
- period  input  PERIOD_W  clock cycles per waveform cycle.
- value  output  OUT_W  registered sample.
- cycle_start  output  1  one-cycle pulse marking step 0 of each waveform cycle.
- busy  output  1  high while in RUN.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, t=0, s=0, period_q=0, mode_q=0, value=0, cycle_start=0, busy=0.
- States:
  - IDLE: t=0, s=0, value=0, busy=0.
    - When en=1, latch period_q<=period and mode_q<=mode, pulse cycle_start, go to RUN.
  - RUN: busy=1.
    - When en=0, go to IDLE next edge; t, s and value clear to 0. No cycle completion is attempted.
    - en=0 wins over a simultaneous step wrap.
- Step length: L = period_q >> STEP_BITS. If L==0, use L=1.
  - Consequence: period < N gives the fastest output, 1 cycle per step.
  - Remainder bits of period are discarded; the realised cycle is N*L clocks.
- Counters in RUN:
  - t counts 0..L-1.
  - When t==L-1: t<=0 and s<=s+1, with s wrapping from N-1 to 0.
- Cycle boundary (s wraps N-1 -> 0): re-latch period_q and mode_q, and pulse cycle_start high for exactly one clock, aligned with s becoming 0.
- Changes to period or mode mid-cycle have no effect until the next boundary.
- Sample function f(mode_q, s), where rep(x) means x bit-replicated MSB-first to fill OUT_W bits (0 maps to 0, all-ones maps to all-ones):
  - saw-up: rep(s).
  - saw-down: ~rep(s).
  - triangle: let lo = s[STEP_BITS-2:0]. Output is rep(lo) when s[MSB]=0, and rep(~lo) when s[MSB]=1.
  - square: all-ones when s < N/2, else 0.
- Output latency: value is registered, value <= f(mode_q, s), so it lags s by one clock. cycle_start is not delayed; it leads value by one clock.
- No arithmetic overflow:
  - t compare is PERIOD_W wide.
  - s wrap is natural modulo N.

Optional Feature:
- Macro: WAVE_DUTY_EN.
- Defined:
  - Adds input duty (STEP_BITS wide).
  - duty is latched into duty_q together with mode and period.
  - square = all-ones while s < duty_q, else 0.
  - duty=0 gives a constant 0 output.
- Undefined:
  - No duty port.
  - Square duty is fixed at N/2.

Test Plan:
1. Reset mid-RUN → value=0, busy=0, cycle_start=0 immediately (asynchronous), with no clock required.
2. STEP_BITS=3, OUT_W=8, period=64, mode=1, en=1 → each step lasts 8 clocks. value sequence is 0,36,73,109,146,182,219,255, repeating. cycle_start pulses every 64 clocks.
3. Same setup, mode=0 → value sequence is 0,85,170,255,255,170,85,0. Then mode=2 → 255×4 steps, then 0×4 steps.
4. period changed from 64 to 128 at step 3 → current cycle completes with 8-clock steps. The next cycle, starting at the cycle_start pulse, uses 16-clock steps. A mode change behaves the same way.
5. period=5 (<N) → L=1; s advances every clock and cycle_start pulses every 8 clocks. period=0 behaves identically.
6. en dropped at step 5 → next edge: value=0, busy=0, s=0. Re-enable gives a cycle_start pulse and the waveform restarts at step 0. With WAVE_DUTY_EN defined, duty=2, mode=2 → 255,255,0,0,0,0,0,0.

Source files
------------

// File: rtl/wave_osc_gen_if.sv
// wave_osc_gen_if
// Purpose: groups the control inputs and sample outputs of wave_osc_gen so
// the upstream note/period logic and the mixer/DAC path share one bundle.
// Signals:
//   en          run enable (level)
//   mode        waveform select: 0 triangle, 1 saw-up, 2 square, 3 saw-down
//   period      clock cycles per waveform cycle
//   duty        square-wave high steps (only when WAVE_DUTY_EN is defined)
//   value       registered sample
//   cycle_start one-clock pulse at step 0 of each waveform cycle
//   busy        high while the generator is running
// Modports: master drives the controls; slave is the generator side.
interface wave_osc_gen_if #(
  parameter int PERIOD_W  = 32,
  parameter int STEP_BITS = 3,
  parameter int OUT_W     = 8
);
  logic                 en;
  logic [1:0]           mode;
  logic [PERIOD_W-1:0]  period;
`ifdef WAVE_DUTY_EN
  logic [STEP_BITS-1:0] duty;
`endif
  logic [OUT_W-1:0]     value;
  logic                 cycle_start;
  logic                 busy;

`ifdef WAVE_DUTY_EN
  modport master (output en, mode, period, duty, input value, cycle_start, busy);
  modport slave  (input en, mode, period, duty, output value, cycle_start, busy);
`else
  modport master (output en, mode, period, input value, cycle_start, busy);
  modport slave  (input en, mode, period, output value, cycle_start, busy);
`endif
endinterface

// File: rtl/wave_osc_gen.sv
// wave_osc_gen
// Purpose: multi-mode periodic waveform generator (triangle, saw-up, square,
// saw-down). Each waveform cycle has N = 2**STEP_BITS steps of
// L = max(1, period >> STEP_BITS) clocks. Period, mode (and duty) are only
// taken on waveform-cycle boundaries so the output never glitches mid-cycle.
// Optional feature macro: WAVE_DUTY_EN adds a duty input setting how many
// steps the square wave stays high (otherwise fixed at N/2).
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    wave_osc_gen_if.slave (en, mode, period, [duty], value,
//          cycle_start, busy)
module wave_osc_gen #(
  parameter int PERIOD_W  = 32,
  parameter int STEP_BITS = 3,
  parameter int OUT_W     = 8
) (
  input  logic           clk,
  input  logic           reset,
  wave_osc_gen_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               r_state, w_state_next;
  logic [PERIOD_W-1:0]  r_t, w_t_next;
  logic [STEP_BITS-1:0] r_s, w_s_next;
  logic [PERIOD_W-1:0]  r_period_q, w_period_next;
  logic [1:0]           r_mode_q, w_mode_next;
  logic [OUT_W-1:0]     r_value, w_value_next;
  logic                 r_cycle_start, w_cycle_start_next;

  logic [PERIOD_W-1:0]  w_len_raw, w_len;
  logic                 w_last_t, w_last_s;
  logic [OUT_W-1:0]     w_rep_s, w_rep_lo, w_wave;
  logic                 w_sq_hi;

  // Step length; a period shorter than N still advances one step per clock.
  assign w_len_raw = r_period_q >> STEP_BITS;
  assign w_len     = (w_len_raw == '0) ? PERIOD_W'(1) : w_len_raw;
  assign w_last_t  = (r_t == w_len - PERIOD_W'(1));
  assign w_last_s  = &r_s;

  // MSB-first bit replication: 0 -> 0, all-ones -> all-ones, evenly spaced.
  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_rep
    assign w_rep_s[OUT_W-1-gi]  = r_s[STEP_BITS-1-(gi % STEP_BITS)];
    assign w_rep_lo[OUT_W-1-gi] = r_s[STEP_BITS-2-(gi % (STEP_BITS-1))];
  end

`ifdef WAVE_DUTY_EN
  logic [STEP_BITS-1:0] r_duty_q, w_duty_next;
  assign w_sq_hi = (r_s < r_duty_q);
`else
  // s < N/2 is simply the top step bit being clear.
  assign w_sq_hi = ~r_s[STEP_BITS-1];
`endif

  always_comb begin
    w_wave = '0;
    case (r_mode_q)
      2'd0:    w_wave = r_s[STEP_BITS-1] ? ~w_rep_lo : w_rep_lo;
      2'd1:    w_wave = w_rep_s;
      2'd2:    w_wave = {OUT_W{w_sq_hi}};
      default: w_wave = ~w_rep_s;
    endcase
  end

  always_comb begin
    w_state_next       = r_state;
    w_t_next           = r_t;
    w_s_next           = r_s;
    w_period_next      = r_period_q;
    w_mode_next        = r_mode_q;
    w_value_next       = r_value;
    w_cycle_start_next = 1'b0;
`ifdef WAVE_DUTY_EN
    w_duty_next        = r_duty_q;
`endif
    case (r_state)
      IDLE: begin
        w_t_next     = '0;
        w_s_next     = '0;
        w_value_next = '0;
        if (bus.en) begin
          w_state_next       = RUN;
          w_period_next      = bus.period;
          w_mode_next        = bus.mode;
          w_cycle_start_next = 1'b1;
`ifdef WAVE_DUTY_EN
          w_duty_next        = bus.duty;
`endif
        end
      end
      default: begin
        if (!bus.en) begin
          // Disable wins over any step wrap on the same edge.
          w_state_next = IDLE;
          w_t_next     = '0;
          w_s_next     = '0;
          w_value_next = '0;
        end else begin
          w_value_next = w_wave;
          if (w_last_t) begin
            w_t_next = '0;
            w_s_next = r_s + STEP_BITS'(1);
            if (w_last_s) begin
              // Cycle boundary: take new settings as s returns to 0.
              w_period_next      = bus.period;
              w_mode_next        = bus.mode;
              w_cycle_start_next = 1'b1;
`ifdef WAVE_DUTY_EN
              w_duty_next        = bus.duty;
`endif
            end
          end else begin
            w_t_next = r_t + PERIOD_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_t           <= '0;
      r_s           <= '0;
      r_period_q    <= '0;
      r_mode_q      <= '0;
      r_value       <= '0;
      r_cycle_start <= 1'b0;
`ifdef WAVE_DUTY_EN
      r_duty_q      <= '0;
`endif
    end else begin
      r_state       <= w_state_next;
      r_t           <= w_t_next;
      r_s           <= w_s_next;
      r_period_q    <= w_period_next;
      r_mode_q      <= w_mode_next;
      r_value       <= w_value_next;
      r_cycle_start <= w_cycle_start_next;
`ifdef WAVE_DUTY_EN
      r_duty_q      <= w_duty_next;
`endif
    end
  end

  assign bus.value       = r_value;
  assign bus.cycle_start = r_cycle_start;
  assign bus.busy        = (r_state == RUN);

endmodule

// File: tb/tb_wave_osc_gen.sv
// tb_wave_osc_gen
// Purpose: randomized and directed stimulus for wave_osc_gen (default
// parameters: PERIOD_W=32, STEP_BITS=3, OUT_W=8), checked every clock
// against a behavioural model. Honours WAVE_DUTY_EN when defined.
module tb_wave_osc_gen;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  wave_osc_gen_if intf ();

  wave_osc_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state: running flag, clocks into current step,
  // current step, settings taken at the last cycle start, expected outputs.
  bit m_run;
  int m_t, m_s, m_per, m_mode, m_dq, m_val;
  bit m_cs;

  int tbl [3][8] = '{'{0, 85, 170, 255, 255, 170, 85, 0},
                     '{0, 36, 73, 109, 146, 182, 219, 255},
                     '{255, 255, 255, 255, 0, 0, 0, 0}};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Saw-up level is the 0..255 scale of s rounded to nearest.
  function automatic int saw_up(input int s);
    return (s * 510 + 7) / 14;
  endfunction

  function automatic int wave(input int md, input int s, input int dq);
    int lvl;
    case (md)
      0: begin
        lvl = (s < 4) ? s : 7 - s;
        return lvl * 85;
      end
      1: return saw_up(s);
`ifdef WAVE_DUTY_EN
      2: return (s < dq) ? 255 : 0;
`else
      2: return (s < 4) ? 255 : 0;
`endif
      default: return 255 - saw_up(s);
    endcase
  endfunction

  task automatic model_reset();
    m_run = 0; m_t = 0; m_s = 0; m_per = 0; m_mode = 0; m_dq = 0;
    m_val = 0; m_cs = 0;
  endtask

  task automatic take_settings();
    m_per  = int'(intf.period);
    m_mode = int'(intf.mode);
`ifdef WAVE_DUTY_EN
    m_dq   = int'(intf.duty);
`endif
  endtask

  task automatic model_edge();
    int len;
    if (reset) begin
      model_reset();
    end else if (!m_run) begin
      m_val = 0;
      m_cs  = 0;
      if (intf.en) begin
        m_run = 1; m_t = 0; m_s = 0; m_cs = 1;
        take_settings();
      end
    end else if (!intf.en) begin
      m_run = 0; m_t = 0; m_s = 0; m_val = 0; m_cs = 0;
    end else begin
      m_val = wave(m_mode, m_s, m_dq);
      len   = m_per / 8;
      if (len == 0) len = 1;
      m_cs = 0;
      m_t  = m_t + 1;
      if (m_t == len) begin
        m_t = 0;
        m_s = (m_s + 1) % 8;
        if (m_s == 0) begin
          m_cs = 1;
          take_settings();
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("value", intf.value, m_val);
    chk("cycle_start", intf.cycle_start, m_cs);
    chk("busy", intf.busy, m_run);
  endtask

  task automatic go_idle();
    intf.en = 1'b0;
    tick();
  endtask

  initial begin
    intf.en = 1'b0; intf.mode = 2'd0; intf.period = '0;
`ifdef WAVE_DUTY_EN
    intf.duty = 3'd4;
`endif
    model_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_value", intf.value, 0);
    chk("rst_busy", intf.busy, 0);
    chk("rst_cs", intf.cycle_start, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Directed step tables: period 64 gives 8-clock steps.
    for (int md = 0; md < 3; md++) begin
      $display("phase table mode=%0d period=64", md);
      go_idle();
      intf.mode = 2'(md); intf.period = 64; intf.en = 1'b1;
      tick();
      chk("start_cs", intf.cycle_start, 1);
      for (int e = 1; e <= 64; e++) begin
        tick();
        if (e % 8 == 4) chk("table", intf.value, tbl[md][e/8]);
        if (e == 32) chk("mid_cs", intf.cycle_start, 0);
        if (e == 64) chk("wrap_cs", intf.cycle_start, 1);
      end
    end

    // Settings changed at step 3 apply only from the next cycle.
    $display("phase latch period 64->128 mode 1->3");
    go_idle();
    intf.mode = 2'd1; intf.period = 64; intf.en = 1'b1;
    tick();
    for (int e = 1; e <= 192; e++) begin
      tick();
      if (e == 26) begin intf.period = 128; intf.mode = 2'd3; end
      if (e <= 64 && e % 8 == 4) chk("old_cycle", intf.value, tbl[1][e/8]);
      if (e > 64 && e <= 128 && (e - 64) % 16 == 8)
        chk("new_cycle", intf.value, 255 - tbl[1][(e-64)/16]);
      if (e == 128) chk("cs_128", intf.cycle_start, 0);
      if (e == 192) chk("cs_192", intf.cycle_start, 1);
    end

    // Short periods: one step per clock.
    for (int k = 0; k < 2; k++) begin
      $display("phase short period=%0d", k * 5);
      go_idle();
      intf.mode = 2'd1; intf.period = 32'(k * 5); intf.en = 1'b1;
      tick();
      for (int e = 1; e <= 24; e++) begin
        tick();
        if (e % 8 == 0) chk("short_cs", intf.cycle_start, 1);
      end
    end

    // Drop enable at step 5, then re-enable.
    $display("phase en drop");
    go_idle();
    intf.mode = 2'd0; intf.period = 64; intf.en = 1'b1;
    for (int e = 0; e <= 44; e++) tick();
    intf.en = 1'b0;
    tick();
    chk("drop_value", intf.value, 0);
    chk("drop_busy", intf.busy, 0);
    intf.en = 1'b1;
    tick();
    chk("reen_cs", intf.cycle_start, 1);
    for (int e = 0; e < 20; e++) tick();

`ifdef WAVE_DUTY_EN
    $display("phase duty=2 square");
    go_idle();
    intf.mode = 2'd2; intf.period = 0; intf.duty = 3'd2; intf.en = 1'b1;
    tick();
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("duty", intf.value, (e <= 2) ? 255 : 0);
    end
    intf.duty = 3'd4;
`endif

    // Asynchronous reset mid-run, no clock edge needed.
    $display("phase async reset");
    go_idle();
    intf.mode = 2'd1; intf.period = 5; intf.en = 1'b1;
    tick(); tick(); tick(); tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_value", intf.value, 0);
    chk("arst_busy", intf.busy, 0);
    chk("arst_cs", intf.cycle_start, 0);
    model_reset();
    tick();
    reset = 1'b0;
    tick();

    // Randomized phases with occasional mid-cycle setting changes.
    for (int p = 0; p < 25; p++) begin
      int n;
      intf.en   = ($urandom_range(0, 7) != 0);
      intf.mode = 2'($urandom_range(0, 3));
      intf.period = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7))
                                                : 32'($urandom_range(8, 300));
`ifdef WAVE_DUTY_EN
      intf.duty = 3'($urandom_range(0, 7));
`endif
      n = $urandom_range(5, 150);
      $display("phase rand %0d en=%0d mode=%0d period=%0d cycles=%0d",
               p, intf.en, intf.mode, intf.period, n);
      for (int e = 0; e < n; e++) begin
        if ($urandom_range(0, 19) == 0) intf.mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 19) == 0) intf.period = 32'($urandom_range(0, 200));
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
